// File: rtl/priority_arbiter_pkg.sv
// Shared definitions for the priority_arbiter slice.
//   arb_state_e  : arbiter state encoding (IDLE = no grant, BUSY = one grant held)
//   calc_index_w : binary index width for n requesters, never less than one bit
package priority_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned calc_index_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/masked_priority_select.sv
// Combinational lowest-index priority selector.
//   req    : candidate vector (already masked by the caller if needed)
//   onehot : one-hot select of the lowest set bit of req, zero if req is zero
//   index  : binary index of the selected bit, zero if req is zero
//   found  : high when req has any bit set
module masked_priority_select
    import priority_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned INDEX_W = calc_index_w(WIDTH)
) (
    input  logic [WIDTH-1:0]   req,
    output logic [WIDTH-1:0]   onehot,
    output logic [INDEX_W-1:0] index,
    output logic               found
);

    always_comb begin
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
                onehot[i] = 1'b1;
                index     = INDEX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered request/grant arbiter for NO_INPUTS requesters sharing one resource.
// A grant is held while its owner keeps requesting; optional round-robin rotation
// and an optional hold-time limit that forces rotation under contention.
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   enable      : arbitration enable, low clears the grant at the next edge
//   request     : per-requester level-sensitive request
//   grant       : registered one-hot grant (or zero)
//   grant_valid : registered OR of grant
//   grant_index : registered binary index of the granted requester, zero when idle
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int unsigned NO_INPUTS   = 4,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned MAX_HOLD    = 0,
    localparam int unsigned INDEX_W    = calc_index_w(NO_INPUTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NO_INPUTS-1:0] request,
    output logic [NO_INPUTS-1:0] grant,
    output logic                 grant_valid,
    output logic [INDEX_W-1:0]   grant_index
);

    arb_state_e           state_q, state_d;
    logic [NO_INPUTS-1:0] grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [INDEX_W-1:0]   ptr_q, ptr_d;

    logic                 hold_limit;
    logic                 keep;
    logic [NO_INPUTS-1:0] cand, ptr_mask, cand_masked;
    logic [NO_INPUTS-1:0] sel_m, sel_u, win;
    logic [INDEX_W-1:0]   idx_m, idx_u, win_idx;
    logic                 found_m, found_u, win_found;

    // Holder keeps the grant while enabled, still requesting and not forced off.
    assign keep = (state_q == BUSY) && enable && (|(request & grant_q)) && !hold_limit;

    always_comb begin
        cand = request;
        // A forced rotation must not hand the grant straight back to the holder.
        if (state_q == BUSY && hold_limit) begin
            cand = request & ~grant_q;
        end
        ptr_mask = '0;
        for (int i = 0; i < NO_INPUTS; i++) begin
            ptr_mask[i] = (INDEX_W'(i) >= ptr_q);
        end
        cand_masked = cand & ptr_mask;
    end

    masked_priority_select #(
        .WIDTH   (NO_INPUTS),
        .INDEX_W (INDEX_W)
    ) u_sel_masked (
        .req    (cand_masked),
        .onehot (sel_m),
        .index  (idx_m),
        .found  (found_m)
    );

    masked_priority_select #(
        .WIDTH   (NO_INPUTS),
        .INDEX_W (INDEX_W)
    ) u_sel_unmasked (
        .req    (cand),
        .onehot (sel_u),
        .index  (idx_u),
        .found  (found_u)
    );

    // Masked search covers ptr..N-1; if empty, the unmasked search is the wrap-around.
    always_comb begin
        if (ROUND_ROBIN != 0 && found_m) begin
            win     = sel_m;
            win_idx = idx_m;
        end else begin
            win     = sel_u;
            win_idx = idx_u;
        end
        win_found = found_u;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        if (!enable) begin
            state_d = IDLE;
            grant_d = '0;
            index_d = '0;
        end else if (!keep) begin
            if (win_found) begin
                state_d = BUSY;
                grant_d = win;
                index_d = win_idx;
                ptr_d   = (win_idx == INDEX_W'(NO_INPUTS - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                index_d = '0;
            end
        end
        valid_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    if (MAX_HOLD != 0) begin : gen_hold
        localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

        logic [HOLD_W-1:0] hold_cnt_q;
        logic              others_req;

        assign others_req = |(request & ~grant_q);
        assign hold_limit = (state_q == BUSY) && (hold_cnt_q == HOLD_LAST) && others_req;

        // Saturates at HOLD_LAST so a lone holder is never forced off.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hold_cnt_q <= '0;
            end else if (enable) begin
                if (keep) begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end else if (win_found) begin
                    hold_cnt_q <= '0;
                end
            end
        end
    end else begin : gen_no_hold
        assign hold_limit = 1'b0;
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_index = index_q;

endmodule

// File: tb/tb_priority_arbiter.sv
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en0, en1, en2;
    logic [3:0] req0, req1, req2;
    logic [3:0] g0, g1, g2;
    logic       v0, v1, v2;
    logic [1:0] i0, i1, i2;

    always #5 clk = ~clk;

    // sel 0: round-robin, unlimited hold
    priority_arbiter #(.NO_INPUTS(4), .ROUND_ROBIN(1), .MAX_HOLD(0)) dut_rr (
        .clk (clk), .reset (reset), .enable (en0), .request (req0),
        .grant (g0), .grant_valid (v0), .grant_index (i0)
    );
    // sel 1: fixed priority
    priority_arbiter #(.NO_INPUTS(4), .ROUND_ROBIN(0), .MAX_HOLD(0)) dut_fx (
        .clk (clk), .reset (reset), .enable (en1), .request (req1),
        .grant (g1), .grant_valid (v1), .grant_index (i1)
    );
    // sel 2: round-robin with hold limit 3
    priority_arbiter #(.NO_INPUTS(4), .ROUND_ROBIN(1), .MAX_HOLD(3)) dut_mh (
        .clk (clk), .reset (reset), .enable (en2), .request (req2),
        .grant (g2), .grant_valid (v2), .grant_index (i2)
    );

    typedef struct {
        int         sel;
        string      name;
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
    } vec_t;

    typedef struct {
        int         sel;
        string      name;
        logic [3:0] grant;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic void add(input int sel, input string name, input logic en,
                                input logic [3:0] req, input logic [3:0] grant);
        vec_t v;
        v.sel = sel; v.name = name; v.en = en; v.req = req; v.grant = grant;
        tbl.push_back(v);
    endfunction

    task automatic drive(input int sel, input logic en, input logic [3:0] req);
        case (sel)
            0:       begin en0 = en; req0 = req; end
            1:       begin en1 = en; req1 = req; end
            default: begin en2 = en; req2 = req; end
        endcase
    endtask

    task automatic compare(input string name, input int sel, input logic [3:0] eg);
        logic [3:0] g;
        logic       v;
        logic [1:0] ix;
        case (sel)
            0:       begin g = g0; v = v0; ix = i0; end
            1:       begin g = g1; v = v1; ix = i1; end
            default: begin g = g2; v = v2; ix = i2; end
        endcase
        n_cmp++;
        if (g !== eg || v !== (|eg) || ix !== oh2idx(eg)) begin
            n_bad++;
            $display("FAIL %s: got grant=%b index=%0d valid=%b, required grant=%b index=%0d valid=%b",
                     name, g, ix, v, eg, oh2idx(eg), |eg);
        end
    endtask

    // Called at a negedge; drives, lets one edge pass, checks, returns at the next negedge.
    task automatic apply(input int sel, input string name, input logic en,
                         input logic [3:0] req, input logic [3:0] eg);
        exp_t e;
        drive(sel, en, req);
        e.sel = sel; e.name = name; e.grant = eg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e.name, e.sel, e.grant);
        @(negedge clk);
    endtask

    initial begin
        // Round-robin rotation, wrap, then enable gating
        add(0, "rr_first",       1'b1, 4'b1111, 4'b0001);
        add(0, "rr_hold0",       1'b1, 4'b1111, 4'b0001);
        add(0, "rr_to1",         1'b1, 4'b1110, 4'b0010);
        add(0, "rr_hold1",       1'b1, 4'b1110, 4'b0010);
        add(0, "rr_to2",         1'b1, 4'b1101, 4'b0100);
        add(0, "rr_hold2",       1'b1, 4'b1101, 4'b0100);
        add(0, "rr_to3",         1'b1, 4'b1011, 4'b1000);
        add(0, "rr_hold3",       1'b1, 4'b1011, 4'b1000);
        add(0, "rr_wrap0",       1'b1, 4'b0111, 4'b0001);
        add(0, "en_grant2",      1'b1, 4'b0100, 4'b0100);
        add(0, "en_hold2",       1'b1, 4'b0100, 4'b0100);
        add(0, "en_off",         1'b0, 4'b0100, 4'b0000);
        add(0, "en_off_idle",    1'b0, 4'b1111, 4'b0000);
        add(0, "en_resume_ptr3", 1'b1, 4'b1111, 4'b1000);
        add(0, "rr_none",        1'b1, 4'b0000, 4'b0000);
        add(0, "rr_single1",     1'b1, 4'b0010, 4'b0010);
        // Fixed priority
        add(1, "fx_pick1",       1'b1, 4'b1010, 4'b0010);
        add(1, "fx_hold1",       1'b1, 4'b1010, 4'b0010);
        add(1, "fx_drop1",       1'b1, 4'b1000, 4'b1000);
        add(1, "fx_no_preempt",  1'b1, 4'b1001, 4'b1000);
        add(1, "fx_drop3",       1'b1, 4'b0001, 4'b0001);
        add(1, "fx_hold0",       1'b1, 4'b0011, 4'b0001);
        add(1, "fx_none",        1'b1, 4'b0000, 4'b0000);
        // Hold limit 3 with contention, then a lone holder
        add(2, "mh_a0_c1",       1'b1, 4'b0101, 4'b0001);
        add(2, "mh_a0_c2",       1'b1, 4'b0101, 4'b0001);
        add(2, "mh_a0_c3",       1'b1, 4'b0101, 4'b0001);
        add(2, "mh_b2_c1",       1'b1, 4'b0101, 4'b0100);
        add(2, "mh_b2_c2",       1'b1, 4'b0101, 4'b0100);
        add(2, "mh_b2_c3",       1'b1, 4'b0101, 4'b0100);
        add(2, "mh_c0_c1",       1'b1, 4'b0101, 4'b0001);
        add(2, "mh_lone_c2",     1'b1, 4'b0001, 4'b0001);
        add(2, "mh_lone_c3",     1'b1, 4'b0001, 4'b0001);
        add(2, "mh_lone_c4",     1'b1, 4'b0001, 4'b0001);
        add(2, "mh_lone_c5",     1'b1, 4'b0001, 4'b0001);
        add(2, "mh_lone_c6",     1'b1, 4'b0001, 4'b0001);
        add(2, "mh_sat_rotate",  1'b1, 4'b0101, 4'b0100);

        reset = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        req0 = 4'b1111; req1 = 4'b1111; req2 = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_rr", 0, 4'b0000);
        compare("reset_fx", 1, 4'b0000);
        compare("reset_mh", 2, 4'b0000);

        @(negedge clk);
        reset = 1'b0;
        en1 = 1'b0; req1 = 4'b0000;
        en2 = 1'b0; req2 = 4'b0000;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].sel, $sformatf("%s[%0d]", tbl[k].name, k),
                  tbl[k].en, tbl[k].req, tbl[k].grant);
        end

        // Asynchronous reset between edges while index 2 holds the grant
        apply(0, "arst_setup", 1'b1, 4'b0100, 4'b0100);
        #2;
        reset = 1'b1;
        #1;
        compare("arst_immediate", 0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        apply(0, "arst_ptr_restart", 1'b1, 4'b1111, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Registered, parametrised request/grant arbiter for N requesters sharing one resource, such as the TX datapath or a statistics bus. It extends one-hot lowest-index priority selection with several additions:
- a clocked grant that is held while the winner keeps requesting;
- a selectable round-robin mode with a rotating priority pointer;
- an optional hold-time limit that forces rotation so one requester cannot starve the others.

## Interface
Parameters:
- NO_INPUTS, default 4: number of requesters, ≥1.
- ROUND_ROBIN, default 1: 0 = fixed priority (index 0 highest); 1 = rotating priority.
- MAX_HOLD, default 0: maximum consecutive grant cycles per tenure; 0 = unlimited.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  arbitration enable; low clears the grant at the next edge.
- request  input  NO_INPUTS  per-requester request, level-sensitive.
- grant  output  NO_INPUTS  registered one-hot grant, or zero.
- grant_valid  output  1  registered, equals the OR of grant.
- grant_index  output  INDEX_W  registered binary index of the granted requester; 0 when there is no grant.

## Operation
- INDEX_W = max(1, clog2(NO_INPUTS)). The hold counter is clog2(MAX_HOLD+1) bits wide and is omitted when MAX_HOLD = 0.
- Two states:
  - IDLE: grant is zero.
  - BUSY: exactly one grant bit is set.
- **Holding.** In BUSY the grant on holder g is kept while all of these are true:
  - enable = 1;
  - request[g] = 1;
  - the hold limit is not reached. The limit is reached when MAX_HOLD ≠ 0, hold_cnt = MAX_HOLD−1, and some other request is active.
- **Re-arbitration.** It happens in IDLE, and in BUSY when holding ends with enable = 1.
  - The winner is taken from the request vector sampled at that edge. In BUSY the current holder is excluded when the hold limit caused the rotation.
  - If there is a winner, the next state is BUSY. If there are no candidates, the next state is IDLE.
- **Fixed mode.** The lowest active index wins.
- **Round-robin mode.**
  - The search starts at pointer ptr, rises through the indices and wraps at NO_INPUTS−1 → 0.
  - On every new grant to index w, ptr ← (w+1) mod NO_INPUTS.
  - ptr is unchanged while a grant is held.
- **Hold counter.** It clears on every new grant and increments each held cycle. It saturates at MAX_HOLD−1 when the holder is alone, so a sole requester keeps the grant indefinitely.
- **enable = 0.** Next state is IDLE with grant cleared. ptr and the counter are frozen.
- **Requester drop.** If the holder drops its request, re-arbitration happens at the same edge. There is no idle bubble when other requests are pending.
- **Reset.** grant = 0, grant_valid = 0, grant_index = 0, ptr = 0, hold_cnt = 0, state IDLE. Reset is asynchronous, so asserting it mid-tenure clears the outputs immediately.
- **NO_INPUTS = 1.** The block degenerates to a registered copy of request[0] & enable.

## Timing
- Latency: a request sampled active at edge k yields a grant visible after edge k (one cycle), provided the requester wins.
- Outputs change only on the clk rising edge or on reset assertion. There are no combinational paths from inputs to outputs.
- Requester protocol: hold request high until the transfer is finished, then drop it for at least one cycle to release.
- Simultaneous holder drop and new requests: the new winner is granted at that same edge, with ptr updated from the new winner.
- Hold limit: with MAX_HOLD = M and contention, the holder keeps the grant for exactly M cycles. At the M-th edge the grant moves to the next candidate.

## Structure
- Shared package: INDEX_W calculation function (clog2 with a minimum of 1) and the state encoding constants IDLE and BUSY.
- Sub-module: masked_priority_select, a combinational lowest-index one-hot selector with an index output.
  - Round-robin is implemented with two instances: one on request masked to indices ≥ ptr, one on the unmasked request. The masked result takes precedence when non-zero.
- Top level holds the state register, ptr, hold counter and output registers.

## Test plan
All scenarios use NO_INPUTS = 4 unless noted.
- **Reset and idle.** Assert reset with request = 4'b1111 → grant = 0, grant_index = 0, grant_valid = 0. Release reset → one cycle later grant = 4'b0001.
- **Fixed priority.** ROUND_ROBIN = 0, request = 4'b1010 → grant = 4'b0010 and held. Drop request[1] → next edge grant = 4'b1000 with no gap.
- **Round-robin rotation.** ROUND_ROBIN = 1, all four request, each holder drops after 2 cycles → grant order 0, 1, 2, 3, 0. Index 3 → 0 exercises the wrap.
- **Hold limit.** MAX_HOLD = 3, requests 0 and 2 held continuously → grant[0] for 3 cycles, grant[2] for 3 cycles, alternating. A lone request[0] keeps the grant beyond 3 cycles.
- **Enable gating.** Deassert enable mid-tenure on index 2 → grant = 0 next edge. Reassert enable → arbitration restarts from ptr = 3.
- **Asynchronous reset mid-tenure.** Assert reset between clock edges while grant = 4'b0100 → outputs zero immediately, and ptr restarts at 0.
